intan_spi_master: RTL and testbench

//  Dual-chip SPI master for the Intan front end. It shifts one 16-bit command out on a shared

---
 rtl/intan_pkg.sv | 24 ++
 rtl/spi_clk_div.sv | 44 ++++
 rtl/intan_spi_master.sv | 150 +++++++++++++++
 tb/tb_intan_spi_master.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/intan_pkg.sv
// ---------------------------------------------------------------
// intan_pkg: state encodings and default sizing for the Intan SPI master
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package intan_pkg;

  localparam int c_WORD_W  = 16;
  localparam int c_CLK_DIV = 4;
  localparam int c_CS_GAP  = 2;

  typedef enum logic [7:0] {
    ST_IDLE = 8'h00,
    ST_CSLO = 8'h01,
    ST_SHFT = 8'h02,
    ST_CSHI = 8'h03,
    ST_PUSH = 8'h04,
    ST_DONE = 8'h05
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------
// spi_clk_div: half-period counter producing one-cycle SCLK rise/fall ticks
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int C_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [C_CW-1:0] c_LAST = C_CW'(CLK_DIV - 1);

  logic [C_CW-1:0] cnt_q;
  logic            phase_q;
  logic            w_wrap;

  // Phase idles at 1 so the first wrap (end of CS setup) reads as a fall,
  // leaving SCLK low for one more half-period before the first rise.
  assign w_wrap      = en_i && (cnt_q == c_LAST);
  assign rise_tick_o = w_wrap && !phase_q;
  assign fall_tick_o = w_wrap && phase_q;

  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == c_LAST) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/intan_spi_master.sv
// ---------------------------------------------------------------
// intan_spi_master: dual-chip SPI master feeding spi2fifo
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module intan_spi_master
  import intan_pkg::*;
#(
  parameter int CLK_DIV = c_CLK_DIV,
  parameter int WORD_W  = c_WORD_W,
  parameter int CS_GAP  = c_CS_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  output logic              fd,
  input  logic [WORD_W-1:0] chip_txd,
  input  logic [1:0]        chip_en,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso0,
  input  logic              spi_miso1,
  output logic [WORD_W-1:0] chip_rxd0,
  output logic [WORD_W-1:0] chip_rxd1,
  output logic              fs0,
  output logic              fs1,
  input  logic              fd_tx
);

  localparam int C_BW = $clog2(WORD_W + 1);
  localparam int C_GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [C_BW-1:0] c_LAST_BIT = C_BW'(WORD_W - 1);
  localparam logic [C_GW-1:0] c_LAST_GAP = C_GW'(CS_GAP - 1);

  state_e            state_q;
  logic [WORD_W-1:0] tx_q, rx0_q, rx1_q, rxd0_q, rxd1_q;
  logic [1:0]        en_q;
  logic [C_BW-1:0]   bit_q;
  logic [C_GW-1:0]   gap_q;
  logic              sclk_q, cs_n_q, fs0_q, fs1_q, fd_q;
  logic              w_div_en, w_rise, w_fall;

  assign w_div_en = (state_q == ST_CSLO) || (state_q == ST_SHFT);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk         (clk),
    .rst         (rst),
    .en_i        (w_div_en),
    .rise_tick_o (w_rise),
    .fall_tick_o (w_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx0_q   <= '0;
      rx1_q   <= '0;
      rxd0_q  <= '0;
      rxd1_q  <= '0;
      en_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      fs0_q   <= 1'b0;
      fs1_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fs) begin
            tx_q    <= chip_txd;
            en_q    <= chip_en;
            bit_q   <= '0;
            cs_n_q  <= 1'b0;
            state_q <= ST_CSLO;
          end
        end
        ST_CSLO: begin
          if (w_fall) state_q <= ST_SHFT;
        end
        ST_SHFT: begin
          if (w_rise) begin
            sclk_q <= 1'b1;
            rx0_q  <= {rx0_q[WORD_W-2:0], spi_miso0};
            rx1_q  <= {rx1_q[WORD_W-2:0], spi_miso1};
          end
          // The command register empties itself, so MOSI rests at 0 after the last bit.
          if (w_fall) begin
            sclk_q <= 1'b0;
            tx_q   <= {tx_q[WORD_W-2:0], 1'b0};
            if (bit_q == c_LAST_BIT) begin
              cs_n_q  <= 1'b1;
              rxd0_q  <= rx0_q;
              rxd1_q  <= rx1_q;
              gap_q   <= '0;
              state_q <= ST_CSHI;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        ST_CSHI: begin
          if (gap_q == c_LAST_GAP) begin
            if (en_q != 2'b00) begin
              fs0_q   <= en_q[0];
              fs1_q   <= en_q[1];
              state_q <= ST_PUSH;
            end else begin
              fd_q    <= 1'b1;
              state_q <= ST_DONE;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ST_PUSH: begin
          if (fd_tx) begin
            fs0_q   <= 1'b0;
            fs1_q   <= 1'b0;
            fd_q    <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!fs) begin
            fd_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_sclk  = sclk_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = tx_q[WORD_W-1];
  assign chip_rxd0 = rxd0_q;
  assign chip_rxd1 = rxd1_q;
  assign fs0       = fs0_q;
  assign fs1       = fs1_q;
  assign fd        = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_intan_spi_master.sv
// ---------------------------------------------------------------
// tb_intan_spi_master: directed vector bench for intan_spi_master
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_intan_spi_master;

  logic        clk, rst, fs, fd, fd_tx;
  logic [15:0] chip_txd, chip_rxd0, chip_rxd1;
  logic [1:0]  chip_en;
  logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso0, spi_miso1, fs0, fs1;

  logic        loop_mode;
  logic [15:0] pat0, pat1, sr0, sr1;
  int          errors, checks, rise_cnt;
  time         t_mosi, t_rise;

  typedef struct {
    logic [15:0] txd;
    logic [1:0]  en;
    bit          loopb;
    logic [15:0] p0, p1, e0, e1;
  } vec_t;

  vec_t vecs[5];

  intan_spi_master dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd),
    .chip_txd(chip_txd), .chip_en(chip_en),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso0(spi_miso0), .spi_miso1(spi_miso1),
    .chip_rxd0(chip_rxd0), .chip_rxd1(chip_rxd1),
    .fs0(fs0), .fs1(fs1), .fd_tx(fd_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: presents its word MSB first, advances on SCLK falling edges.
  always @(negedge spi_cs_n) begin
    sr0 <= pat0;
    sr1 <= pat1;
  end
  always @(negedge spi_sclk) begin
    if (!spi_cs_n) begin
      sr0 <= {sr0[14:0], 1'b0};
      sr1 <= {sr1[14:0], 1'b0};
    end
  end
  assign spi_miso0 = loop_mode ? spi_mosi  : sr0[15];
  assign spi_miso1 = loop_mode ? ~spi_mosi : sr1[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(spi_mosi) t_mosi = $time;

  // Every SCLK rise: CS asserted, MOSI settled a half-period, 80 ns between rises.
  always @(posedge spi_sclk) begin
    chk("rise_cs_n", {31'd0, spi_cs_n}, 32'd0);
    chk("mosi_setup", {31'd0, ($time - t_mosi) >= 40}, 32'd1);
    if (rise_cnt > 0) chk("sclk_period", 32'($time - t_rise), 32'd80);
    t_rise = $time;
    rise_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from fs rising to fd, leaving fs high.
  task automatic run_frame(input vec_t v, input string tag);
    int cyc, t_push, t_fd, n0, n1;
    logic seen0, seen1;
    loop_mode = v.loopb;
    pat0 = v.p0;
    pat1 = v.p1;
    chip_txd = v.txd;
    chip_en = v.en;
    rise_cnt = 0;
    fs = 1'b1;
    cyc = 0; t_push = -1; t_fd = -1; n0 = 0; n1 = 0; seen0 = 0; seen1 = 0;
    while (t_fd < 0 && cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 2) begin
        chip_txd = ~v.txd;
        chip_en  = ~v.en;
      end
      seen0 |= fs0;
      seen1 |= fs1;
      if (fs0) n0++;
      if (fs1) n1++;
      if ((fs0 || fs1) && t_push < 0) t_push = cyc;
      fd_tx = ((t_push >= 0) && (cyc == t_push + 3)) || (cyc >= 10 && cyc < 12);
      if (fd && t_fd < 0) t_fd = cyc;
    end
    fd_tx = 1'b0;
    chk({tag, "_fd_lat"}, t_fd, (v.en == 2'b00) ? 32'd135 : 32'd139);
    chk({tag, "_rxd0"}, {16'd0, chip_rxd0}, {16'd0, v.e0});
    chk({tag, "_rxd1"}, {16'd0, chip_rxd1}, {16'd0, v.e1});
    chk({tag, "_fs0_cycles"}, n0, v.en[0] ? 32'd4 : 32'd0);
    chk({tag, "_fs1_cycles"}, n1, v.en[1] ? 32'd4 : 32'd0);
    if (v.en != 2'b00) chk({tag, "_push_lat"}, t_push, 32'd135);
    chk({tag, "_rises"}, rise_cnt, 32'd16);
    chk({tag, "_idle_bus"}, {29'd0, spi_cs_n, spi_sclk, fs0 | fs1}, 32'b100);
  endtask

  // fs held high after fd: no new frame; then fs low for one clk.
  task automatic end_frame(input string tag);
    logic bad;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!fd || !spi_cs_n) bad = 1;
    end
    chk({tag, "_fd_hold"}, {31'd0, bad}, 32'd0);
    fs = 1'b0;
    tick();
    chk({tag, "_fd_drop"}, {31'd0, fd}, 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0; rise_cnt = 0;
    t_mosi = 0; t_rise = 0;
    rst = 1'b1; fs = 1'b0; fd_tx = 1'b0;
    chip_txd = '0; chip_en = '0;
    loop_mode = 1'b1; pat0 = '0; pat1 = '0;

    vecs[0] = '{txd: 16'h2F9F, en: 2'b11, loopb: 1'b1, p0: 16'h0, p1: 16'h0, e0: 16'h2F9F, e1: 16'hD060};
    vecs[1] = '{txd: 16'h1234, en: 2'b10, loopb: 1'b0, p0: 16'h6C66, p1: 16'hF432, e0: 16'h6C66, e1: 16'hF432};
    vecs[2] = '{txd: 16'hA5C3, en: 2'b00, loopb: 1'b1, p0: 16'h0, p1: 16'h0, e0: 16'hA5C3, e1: 16'h5A3C};
    vecs[3] = '{txd: 16'hFFFF, en: 2'b01, loopb: 1'b0, p0: 16'h8001, p1: 16'h7FFE, e0: 16'h8001, e1: 16'h7FFE};
    vecs[4] = '{txd: 16'h0000, en: 2'b11, loopb: 1'b1, p0: 16'h0, p1: 16'h0, e0: 16'h0000, e1: 16'hFFFF};

    repeat (3) tick();
    chk("reset_ctrl", {26'd0, spi_cs_n, spi_sclk, spi_mosi, fs0, fs1, fd}, 32'b100000);
    chk("reset_rxd", {chip_rxd1, chip_rxd0}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_frame(vecs[i], tag);
      end_frame(tag);
    end

    // Reset pulsed during bit 7 of the shift phase.
    begin
      int n;
      logic stray;
      loop_mode = 1'b1;
      chip_txd = 16'hC3A5;
      chip_en = 2'b11;
      rise_cnt = 0;
      fs = 1'b1;
      n = 0;
      while (rise_cnt < 8 && n < 300) begin
        tick();
        n++;
      end
      chk("abort_reach_bit7", rise_cnt, 32'd8);
      rst = 1'b1;
      tick();
      chk("abort_ctrl", {26'd0, spi_cs_n, spi_sclk, spi_mosi, fs0, fs1, fd}, 32'b100000);
      chk("abort_rxd", {chip_rxd1, chip_rxd0}, 32'd0);
      rst = 1'b0;
      fs = 1'b0;
      stray = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (fs0 || fs1 || fd || !spi_cs_n) stray = 1;
      end
      chk("abort_no_push", {31'd0, stray}, 32'd0);
      run_frame(vecs[0], "post_abort");
      end_frame("post_abort");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
